// File: rtl/donut_raygen.sv
// Ray-launch sequencer for the donut hit-test core: walks the pixel grid, launches one
// march per pixel and returns a shaded pixel on a valid/ready handshake.
module donut_raygen #(
   parameter int HRES  = 4,
   parameter int VRES  = 3,
   parameter int STEPS = 8,
   parameter int CAM_Z = -1280,
   parameter int RX0   = -480,
   parameter int RY0   = -360,
   parameter int DX    = 12,
   parameter int DY    = 12,
   parameter int RZ    = 512
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_go,
   input  logic signed [15:0] lx_in,
   input  logic signed [15:0] ly_in,
   input  logic signed [15:0] lz_in,
   input  logic               hit,
   input  logic signed [15:0] light,
   output logic               start,
   output logic signed [15:0] px,
   output logic signed [15:0] py,
   output logic signed [15:0] pz,
   output logic signed [15:0] rx,
   output logic signed [15:0] ry,
   output logic signed [15:0] rz,
   output logic signed [15:0] lx,
   output logic signed [15:0] ly,
   output logic signed [15:0] lz,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [7:0]         pix_x,
   output logic [7:0]         pix_y,
   output logic               pix_hit,
   output logic [5:0]         pix_shade,
   output logic               busy,
   output logic               frame_done
);

   typedef enum logic [2:0] {IDLE, LAUNCH, MARCH, SAMPLE, OUT} state_t;

   state_t      state;
   logic [7:0]  col;
   logic [7:0]  row;
   logic [15:0] step_cnt;
   logic [5:0]  shade_next;
   logic        last_col;
   logic        last_row;

   assign px = '0;
   assign py = '0;
   assign pz = 16'(CAM_Z);
   assign rz = 16'(RZ);

   assign last_col = (col == 8'(HRES - 1));
   assign last_row = (row == 8'(VRES - 1));

   // Misses and back-facing light are black; bright light saturates at full scale.
   always_comb begin
      shade_next = '0;
      if (!hit || light <= 16'sd0)
         shade_next = '0;
      else if (light >= 16'sd1024)
         shade_next = 6'd63;
      else
         shade_next = light[9:4];
   end

   // start, busy and frame_done are registered alongside the state so they
   // line up exactly with LAUNCH, non-IDLE and the cycle after the final accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         start      <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         pix_valid  <= 1'b0;
         rx         <= 16'(RX0);
         ry         <= 16'(RY0);
         lx         <= '0;
         ly         <= '0;
         lz         <= '0;
         pix_x      <= '0;
         pix_y      <= '0;
         pix_hit    <= 1'b0;
         pix_shade  <= '0;
         col        <= '0;
         row        <= '0;
         step_cnt   <= '0;
      end else begin
         start      <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_go) begin
                  lx    <= lx_in;
                  ly    <= ly_in;
                  lz    <= lz_in;
                  rx    <= 16'(RX0);
                  ry    <= 16'(RY0);
                  col   <= '0;
                  row   <= '0;
                  start <= 1'b1;
                  busy  <= 1'b1;
                  state <= LAUNCH;
               end
            end
            LAUNCH: begin
               step_cnt <= '0;
               state    <= MARCH;
            end
            MARCH: begin
               if (step_cnt == 16'(STEPS - 1))
                  state <= SAMPLE;
               else
                  step_cnt <= step_cnt + 16'd1;
            end
            SAMPLE: begin
               pix_hit   <= hit;
               pix_shade <= shade_next;
               pix_x     <= col;
               pix_y     <= row;
               pix_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (pix_ready) begin
                  pix_valid <= 1'b0;
                  if (!last_col) begin
                     col   <= col + 8'd1;
                     rx    <= rx + 16'(DX);
                     start <= 1'b1;
                     state <= LAUNCH;
                  end else if (!last_row) begin
                     col   <= '0;
                     rx    <= 16'(RX0);
                     row   <= row + 8'd1;
                     ry    <= ry + 16'(DY);
                     start <= 1'b1;
                     state <= LAUNCH;
                  end else begin
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                     state      <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
